// File: rtl/ifu_redirect_ctrl_pkg.sv
// Shared types and constants for the IFU redirect controller.
// Holds the FSM state enum, fetch-group width and RAS depth default.
package ifu_redirect_ctrl_pkg;

    typedef enum logic {
        NORMAL  = 1'b0,
        WAIT_DS = 1'b1
    } state_e;

    localparam int FETCH_W       = 2;
    localparam int RAS_DEPTH_DEF = 8;

    // PC of slot idx within a group starting at base.
    function automatic logic [31:0] slot_pc(
        input logic [31:0] base,
        input logic        idx
    );
        return base + (idx ? 32'd4 : 32'd0);
    endfunction

endpackage

// File: rtl/ifu_ras.sv
// Circular return address stack with saturating occupancy count.
// Ports: clk, rst, push_i, pop_i, push_data_i, top_o, empty_o.
//   A simultaneous pop and push pops first, then pushes.
//   A push when full overwrites the oldest entry.
module ifu_ras
    import ifu_redirect_ctrl_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] push_data_i,
    output logic [31:0] top_o,
    output logic        empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   ent_q [DEPTH];
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] ptr_pop;
    logic [PW-1:0] top_idx;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_pop;

    // ptr_q is the next free slot; the top lives just below it.
    assign top_idx = ptr_q - PW'(1);
    assign top_o   = ent_q[top_idx];
    assign empty_o = (cnt_q == '0);

    always_comb begin
        ptr_pop = ptr_q;
        cnt_pop = cnt_q;
        if (pop_i && !empty_o) begin
            ptr_pop = ptr_q - PW'(1);
            cnt_pop = cnt_q - CW'(1);
        end
        ptr_d = ptr_pop;
        cnt_d = cnt_pop;
        if (push_i) begin
            ptr_d = ptr_pop + PW'(1);
            if (cnt_pop != FULL) begin
                cnt_d = cnt_pop + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (push_i) begin
                ent_q[ptr_pop] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/ifu_redirect_ctrl.sv
// Front-end redirect controller: picks the first taken CT of a
// two-slot fetch group, honours the branch delay slot and issues a
// one-cycle registered redirect. Owns the RAS for jr $31.
// Ports: grp_* / slot_valid_i / pd_* / bpd_taken_i (fetch group in),
//   out_valid_o / out_slot_mask_o / out_ready_i (to instr queue),
//   redirect_o / redirect_pc_o (to PC gen), flush_i (backend kill).
module ifu_redirect_ctrl
    import ifu_redirect_ctrl_pkg::*;
#(
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        grp_valid_i,
    output logic        grp_ready_o,
    input  logic [31:0] grp_pc_i,
    input  logic [1:0]  slot_valid_i,
    input  logic [1:0]  pd_isJ_i,
    input  logic [1:0]  pd_isBr_i,
    input  logic [1:0]  pd_jr_i,
    input  logic [1:0]  pd_isLink_i,
    input  logic [1:0]  pd_isReturn_i,
    input  logic [63:0] pd_target_i,
    input  logic [1:0]  bpd_taken_i,
    output logic        out_valid_o,
    output logic [1:0]  out_slot_mask_o,
    input  logic        out_ready_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    state_e      state_q;
    state_e      state_d;
    logic        redirect_q;
    logic        redirect_d;
    logic [31:0] redirect_pc_q;
    logic [31:0] redirect_pc_d;
    logic [31:0] pend_pc_q;
    logic [31:0] pend_pc_d;

    logic [1:0]  ct;
    logic        ct_any;
    logic        c_idx;
    logic        c_jr;
    logic        c_ret;
    logic        c_link;
    logic        redir;
    logic [31:0] c_pc;
    logic [31:0] c_tgt;
    logic        acc;

    logic        ras_push;
    logic        ras_pop;
    logic [31:0] ras_top;
    logic        ras_empty;

    assign ct     = slot_valid_i
                  & (pd_isJ_i | (pd_isBr_i & bpd_taken_i));
    assign ct_any = |ct;
    assign c_idx  = ~ct[0];
    assign c_jr   = pd_jr_i[c_idx];
    assign c_ret  = pd_isReturn_i[c_idx];
    assign c_link = pd_isLink_i[c_idx];
    assign c_pc   = slot_pc(grp_pc_i, c_idx);

    assign c_tgt = c_jr ? ras_top
                 : (c_idx ? pd_target_i[63:32] : pd_target_i[31:0]);

    // Plain jr, or a return with nothing predicted, leaves the
    // target to the backend.
    assign redir = ct_any & (~c_jr | (c_ret & ~ras_empty));

    // Groups arriving under a redirect or flush are wrong-path:
    // consume and drop them.
    assign grp_ready_o = out_ready_i | redirect_q | flush_i;
    assign out_valid_o = grp_valid_i & ~redirect_q & ~flush_i;
    assign acc         = grp_valid_i & grp_ready_o & out_valid_o;

    always_comb begin
        state_d         = state_q;
        redirect_d      = 1'b0;
        redirect_pc_d   = redirect_pc_q;
        pend_pc_d       = pend_pc_q;
        out_slot_mask_o = slot_valid_i;
        ras_push        = 1'b0;
        ras_pop         = 1'b0;

        unique case (state_q)
            NORMAL: begin
                // Valid slots up to c always equal slot_valid_i
                // since slot 1 valid implies slot 0 valid.
                out_slot_mask_o = slot_valid_i;
                if (acc && ct_any) begin
                    ras_push = c_link;
                    ras_pop  = c_ret;
                end
                if (acc && redir) begin
                    if (!c_idx && slot_valid_i[1]) begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = c_tgt;
                    end else begin
                        pend_pc_d = c_tgt;
                        state_d   = WAIT_DS;
                    end
                end
            end
            WAIT_DS: begin
                out_slot_mask_o = 2'b01;
                if (acc) begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = pend_pc_q;
                    state_d       = NORMAL;
                end
            end
        endcase

        if (flush_i) begin
            state_d = NORMAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= NORMAL;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            pend_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            pend_pc_q     <= pend_pc_d;
        end
    end

    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;

    ifu_ras #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (c_pc + 32'd8),
        .top_o       (ras_top),
        .empty_o     (ras_empty)
    );

endmodule
